counter_scan7s: RTL and testbench

COUNTER_SCAN7S -- requirements
Module: counter_scan7s

---
 rtl/counter_scan7s_if.sv | 24 ++
 rtl/counter_scan7s.sv | 131 +++++++++++++
 tb/tb_counter_scan7s.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/counter_scan7s_if.sv
// Control, count and display signals of the scanned BCD counter.
interface counter_scan7s_if #(
  parameter int DIGITS = 4,
  parameter int SEL_W  = 2
);
  logic                  ena;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  blank_lz;
  logic                  co;
  logic [4*DIGITS-1:0]   count;
  logic [SEL_W-1:0]      scan_select;
  logic [7:0]            seg7;

  modport master (
    output ena, up, load, load_val, blank_lz,
    input  co, count, scan_select, seg7
  );
  modport slave (
    input  ena, up, load, load_val, blank_lz,
    output co, count, scan_select, seg7
  );
endinterface

// File: rtl/counter_scan7s.sv
// Multi-digit up/down BCD counter with wrap pulse and a time-multiplexed
// seven-segment driver with optional leading-zero blanking.
module counter_scan7s_digit (
   input  logic [3:0] d_i,
   input  logic       cin_i,
   input  logic       up_i,
   output logic [3:0] d_o,
   output logic       cout_o
);
   always_comb begin
      d_o    = d_i;
      cout_o = 1'b0;
      if (cin_i) begin
         if (up_i) begin
            if (d_i == 4'd9) begin
               d_o    = 4'd0;
               cout_o = 1'b1;
            end else d_o = d_i + 4'd1;
         end else begin
            if (d_i == 4'd0) begin
               d_o    = 4'd9;
               cout_o = 1'b1;
            end else d_o = d_i - 4'd1;
         end
      end
   end
endmodule

module counter_scan7s #(
   parameter int DIGITS   = 4,
   parameter int SEL_W    = 2,
   parameter int SCAN_DIV = 4
) (
   input logic clk,
   input logic rst_n,
   counter_scan7s_if.slave bus
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIGITS-1:0][3:0] count_q, count_d, step_w, load_w;
   logic [DIGITS:0]        carry_w;
   logic                   co_q, co_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [3:0]             dig_w;
   logic                   blank_w;
   logic [7:0]             seg_w;

   // Each digit advances only when every lower digit wrapped this cycle.
   assign carry_w[0] = bus.ena;
   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      counter_scan7s_digit u_dig (
         .d_i   (count_q[g]),
         .cin_i (carry_w[g]),
         .up_i  (bus.up),
         .d_o   (step_w[g]),
         .cout_o(carry_w[g+1])
      );
      assign load_w[g] = (bus.load_val[4*g +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*g +: 4];
   end

   always_comb begin
      count_d = count_q;
      co_d    = 1'b0;
      if (bus.load) count_d = load_w;
      else if (bus.ena) begin
         count_d = step_w;
         co_d    = carry_w[DIGITS];
      end
   end

   always_comb begin
      div_d = div_q + DIV_W'(1);
      sel_d = sel_q;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
         div_d = '0;
         sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         co_q    <= 1'b0;
         div_q   <= '0;
         sel_q   <= '0;
      end else begin
         count_q <= count_d;
         co_q    <= co_d;
         div_q   <= div_d;
         sel_q   <= sel_d;
      end
   end

   // Walk from the top digit down so "seen" means a nonzero digit at or above i.
   always_comb begin
      logic seen;
      seen    = 1'b0;
      dig_w   = '0;
      blank_w = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen = seen | (count_q[i] != 4'd0);
         if (sel_q == SEL_W'(i)) begin
            dig_w   = count_q[i];
            blank_w = bus.blank_lz && (i != 0) && !seen;
         end
      end
   end

   always_comb begin
      case (dig_w)
         4'd0:    seg_w = 8'h3F;
         4'd1:    seg_w = 8'h06;
         4'd2:    seg_w = 8'h5B;
         4'd3:    seg_w = 8'h4F;
         4'd4:    seg_w = 8'h66;
         4'd5:    seg_w = 8'h6D;
         4'd6:    seg_w = 8'h7D;
         4'd7:    seg_w = 8'h07;
         4'd8:    seg_w = 8'h7F;
         4'd9:    seg_w = 8'h6F;
         default: seg_w = 8'h00;
      endcase
      if (blank_w) seg_w = 8'h00;
   end

   assign bus.count       = count_q;
   assign bus.co          = co_q;
   assign bus.scan_select = sel_q;
   assign bus.seg7        = seg_w;
endmodule

// File: tb/tb_counter_scan7s.sv
// Scoreboard bench for counter_scan7s: a decimal reference model predicts each
// cycle's count/co/scan/segments, results are queued and compared after the edge.
module tb_counter_scan7s;
   localparam int DIGITS = 4, SEL_W = 2, SCAN_DIV = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   counter_scan7s_if #(.DIGITS(DIGITS), .SEL_W(SEL_W)) bus ();

   counter_scan7s #(.DIGITS(DIGITS), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] cnt;
      logic        co;
      logic [1:0]  sel;
      logic [7:0]  seg;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   int m_cnt, m_div, m_sel, co_seen;
   bit m_co;
   logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int from_bcd(logic [15:0] b);
      int r = 0;
      for (int i = 3; i >= 0; i--) begin
         int d = int'(b[4*i +: 4]);
         if (d > 9) d = 0;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_of(int cnt, int sel, bit blank);
      int p = 1;
      for (int i = 0; i < sel; i++) p *= 10;
      if (blank && sel > 0 && cnt < p) return 8'h00;
      return tbl[(cnt / p) % 10];
   endfunction

   task automatic m_reset();
      m_cnt = 0; m_co = 0; m_div = 0; m_sel = 0;
   endtask

   task automatic step();
      exp_t e;
      m_co = 0;
      if (bus.load) m_cnt = from_bcd(bus.load_val);
      else if (bus.ena) begin
         if (bus.up) begin
            if (m_cnt == 9999) begin m_cnt = 0; m_co = 1; end else m_cnt++;
         end else begin
            if (m_cnt == 0) begin m_cnt = 9999; m_co = 1; end else m_cnt--;
         end
      end
      if (m_div == SCAN_DIV - 1) begin
         m_div = 0;
         m_sel = (m_sel + 1) % DIGITS;
      end else m_div++;
      e.cnt = to_bcd(m_cnt);
      e.co  = m_co;
      e.sel = 2'(m_sel);
      e.seg = seg_of(m_cnt, m_sel, bus.blank_lz);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("count", bus.count, e.cnt);
         chk("co", bus.co, e.co);
         chk("scan_select", bus.scan_select, e.sel);
         chk("seg7", bus.seg7, e.seg);
      end
      if (bus.co) co_seen++;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_count"}, bus.count, 16'h0000);
      chk({tag, "_co"}, bus.co, 1'b0);
      chk({tag, "_sel"}, bus.scan_select, 2'd0);
      chk({tag, "_seg7"}, bus.seg7, 8'h3F);
   endtask

   initial begin
      bus.ena = 0; bus.up = 1; bus.load = 0; bus.load_val = '0; bus.blank_lz = 0;
      #1 rst_n = 1'b0;
      #1 chk_reset_state("rst_async");
      @(negedge clk);
      chk_reset_state("rst_hold");
      rst_n = 1'b1;
      m_reset();

      // full up-count sweep with exactly one wrap
      bus.ena = 1; bus.up = 1; co_seen = 0;
      repeat (10000) step();
      chk("co_once", co_seen, 1);
      chk("sweep_end", bus.count, 16'h0000);

      // decrement across a digit boundary, then borrow-wrap
      bus.ena = 0; bus.load = 1; bus.load_val = 16'h0100; step();
      bus.load = 0; bus.ena = 1; bus.up = 0; step(); step();
      chk("dec_0098", bus.count, 16'h0098);
      bus.load = 1; bus.load_val = 16'h0000; step();
      bus.load = 0; step();
      chk("dec_wrap", bus.count, 16'h9999);
      chk("dec_wrap_co", bus.co, 1'b1);
      bus.ena = 0; step();

      // invalid digits sanitized, load beats ena
      bus.load = 1; bus.ena = 1; bus.up = 1; bus.load_val = 16'h1A3F; step();
      chk("load_sanitize", bus.count, 16'h1030);

      // hold with scanning
      bus.load = 0; bus.ena = 0;
      repeat (32) step();

      // leading-zero blanking
      bus.load = 1; bus.load_val = 16'h0042; step();
      bus.load = 0; bus.blank_lz = 1;
      repeat (16) step();
      bus.blank_lz = 0;
      repeat (16) step();
      bus.load = 1; bus.load_val = 16'h0000; bus.blank_lz = 1; step();
      bus.load = 0;
      repeat (16) step();

      // random mix
      for (int i = 0; i < 400; i++) begin
         bus.ena      = 1'($urandom_range(0, 1));
         bus.up       = 1'($urandom_range(0, 1));
         bus.load     = ($urandom_range(0, 15) == 0);
         bus.load_val = 16'($urandom);
         bus.blank_lz = 1'($urandom_range(0, 1));
         step();
      end

      // asynchronous reset mid-scan
      bus.load = 1; bus.ena = 0; bus.load_val = 16'h1234; bus.blank_lz = 0; step();
      bus.load = 0; bus.ena = 1; bus.up = 1;
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1 chk_reset_state("rst_mid");
      m_reset();
      @(negedge clk);
      chk_reset_state("rst_mid_hold");
      rst_n = 1'b1;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
